// File: rtl/dcache_ctrl_param.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Fills whole blocks over a req/ack memory port and counts read hits/misses.
module dcache_ctrl_param #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LINES  = 32,
    parameter int WORDS  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] Data_in,
    output logic [DATA_W-1:0] Data_out,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    // state  | meaning
    // IDLE   | serve read hits, launch fills and stores
    // FILL   | fetch block word by word from memory
    // WRITE  | store forwarded to memory, waiting for ack
    // WDONE  | one stall-free cycle so the core retires the store
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_WDONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [OFF_W-1:0] cnt_q, cnt_d;
    logic [LINES-1:0] valid_q, valid_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic [TAG_W-1:0]  tag_ram  [LINES];
    logic [DATA_W-1:0] data_ram [LINES*WORDS];

    logic [OFF_W-1:0]       offset;
    logic [IDX_W-1:0]       index;
    logic [TAG_W-1:0]       tag;
    logic                   hit;
    logic                   data_we;
    logic                   tag_we;
    logic [IDX_W+OFF_W-1:0] data_wptr;
    logic [DATA_W-1:0]      data_wdata;

    assign offset    = WA[OFF_W-1:0];
    assign index     = WA[OFF_W +: IDX_W];
    assign tag       = WA[ADDR_W-1 -: TAG_W];
    assign hit       = valid_q[index] && (tag_ram[index] == tag);
    assign Data_out  = hit ? data_ram[{index, offset}] : '0;
    assign mem_wdata = Data_in;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        stall      = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = WA;
        data_we    = 1'b0;
        tag_we     = 1'b0;
        data_wptr  = {index, offset};
        data_wdata = Data_in;
        case (state_q)
            S_IDLE: begin
                if (MemWrite) begin
                    stall   = 1'b1;
                    state_d = S_WRITE;
                end else if (MemRead) begin
                    if (hit) begin
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                    end else begin
                        stall   = 1'b1;
                        state_d = S_FILL;
                        cnt_d   = '0;
                        // the old block is being overwritten word by word
                        valid_d[index] = 1'b0;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                    end
                end
            end
            S_FILL: begin
                stall    = 1'b1;
                mem_req  = 1'b1;
                mem_addr = {tag, index, cnt_q};
                if (mem_ack) begin
                    data_we    = 1'b1;
                    data_wptr  = {index, cnt_q};
                    data_wdata = mem_rdata;
                    cnt_d      = cnt_q + 1'b1;
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        valid_d[index] = 1'b1;
                        tag_we         = 1'b1;
                        state_d        = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                stall   = 1'b1;
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) begin
                    data_we = hit;
                    state_d = S_WDONE;
                end
            end
            S_WDONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Arrays carry no reset; an aborted fill must not leave partial writes behind a valid bit.
    always_ff @(posedge clk) begin
        if (data_we && !RST) data_ram[data_wptr] <= data_wdata;
        if (tag_we && !RST) tag_ram[index] <= tag;
    end
endmodule

// File: tb/tb_dcache_ctrl_param.sv
// Bench for dcache_ctrl_param: table of core accesses against a latency-programmable
// backing memory, plus reset-during-fill and counter saturation sequences.
module tb_dcache_ctrl_param;
    localparam int AW = 10;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          RST;
    logic          MemRead, MemWrite;
    logic [AW-1:0] WA;
    logic [DW-1:0] Data_in, Data_out;
    logic          stall, mem_req, mem_we, mem_ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [CW-1:0] hit_cnt, miss_cnt;

    dcache_ctrl_param #(.ADDR_W(AW), .DATA_W(DW), .LINES(32), .WORDS(4), .CNT_W(CW)) dut (
        .clk(clk), .RST(RST), .MemRead(MemRead), .MemWrite(MemWrite), .WA(WA),
        .Data_in(Data_in), .Data_out(Data_out), .stall(stall), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [1024];
    int lat = 2;
    int wait_cnt = 0;
    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [$];

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        int          stall_cyc;
        int          hits;
        int          misses;
    } vec_t;
    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: acks each request lat cycles after it is first seen.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (mem_ack) begin
                mem_ack  = 1'b0;
                wait_cnt = 0;
            end
            if (mem_req) begin
                wait_cnt++;
                if (wait_cnt >= lat) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                    if (mem_we) mem[mem_addr] = mem_wdata;
                    wait_cnt  = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    task automatic do_op(input bit wr, input logic [9:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input int exp_stall);
        int  ncyc;
        bit  done;
        bit  seen;
        logic [9:0] exp_addr;
        ncyc = 0;
        done = 0;
        seen = 0;
        exp_addr = wr ? addr : {addr[9:2], 2'b00};
        MemRead  = !wr;
        MemWrite = wr;
        WA       = addr;
        Data_in  = wdata;
        if (!wr) exp_q.push_back(exp_rdata);
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
            ncyc++;
            if (mem_req && !seen) begin
                seen = 1;
                chk("req_we", {31'b0, mem_we}, {31'b0, wr});
                chk("req_addr", {22'b0, mem_addr}, {22'b0, exp_addr});
                if (wr) chk("req_wdata", mem_wdata, wdata);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout: addr 0x%0h still stalled after 300 cycles", addr);
        end
        chk("stall_cycles", ncyc, exp_stall);
        if (!wr) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: got 0x%0h expected an entry", Data_out);
            end else begin
                chk("rdata", Data_out, exp_q.pop_front());
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST      = 1'b1;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        WA       = '0;
        Data_in  = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 32'hA0 + (a % 4);
        for (int k = 0; k < 4; k++) mem[10'h090 + k] = 32'hB0 + k;

        //           wr addr     wdata         lat rdata         stall hits miss
        vecs[0]  = '{0, 10'h010, 32'h0,        2, 32'hA0,       9, 1,  1};
        vecs[1]  = '{0, 10'h011, 32'h0,        2, 32'hA1,       0, 2,  1};
        vecs[2]  = '{0, 10'h012, 32'h0,        2, 32'hA2,       0, 3,  1};
        vecs[3]  = '{0, 10'h013, 32'h0,        2, 32'hA3,       0, 4,  1};
        vecs[4]  = '{1, 10'h012, 32'hDEADBEEF, 3, 32'h0,        4, 4,  1};
        vecs[5]  = '{0, 10'h012, 32'h0,        3, 32'hDEADBEEF, 0, 5,  1};
        vecs[6]  = '{1, 10'h3F0, 32'h12345678, 1, 32'h0,        2, 5,  1};
        vecs[7]  = '{0, 10'h3F0, 32'h0,        1, 32'h12345678, 5, 6,  2};
        vecs[8]  = '{0, 10'h090, 32'h0,        2, 32'hB0,       9, 7,  3};
        vecs[9]  = '{0, 10'h010, 32'h0,        1, 32'hA0,       5, 8,  4};
        vecs[10] = '{0, 10'h012, 32'h0,        1, 32'hDEADBEEF, 0, 9,  4};
        vecs[11] = '{1, 10'h091, 32'hCAFEF00D, 2, 32'h0,        3, 9,  4};
        vecs[12] = '{0, 10'h091, 32'h0,        1, 32'hCAFEF00D, 5, 10, 5};
        vecs[13] = '{0, 10'h013, 32'h0,        1, 32'hA3,       5, 11, 6};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        chk("rst_mem_req", {31'b0, mem_req}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_hit_cnt", {28'b0, hit_cnt}, 32'h0);
        chk("rst_miss_cnt", {28'b0, miss_cnt}, 32'h0);
        chk("rst_data_out", Data_out, 32'h0);
        @(posedge clk);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 14; i++) begin
            lat = vecs[i].lat;
            do_op(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].stall_cyc);
            chk("hit_cnt", {28'b0, hit_cnt}, vecs[i].hits);
            chk("miss_cnt", {28'b0, miss_cnt}, vecs[i].misses);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        @(posedge clk);
        #1;

        // Reset lands in the second fill cycle of a conflict miss.
        lat     = 2;
        MemRead = 1'b1;
        WA      = 10'h090;
        @(negedge clk);
        chk("abort_miss_stall", {31'b0, stall}, 32'h1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        RST     = 1'b1;
        MemRead = 1'b0;
        @(negedge clk);
        chk("abort_fill_req", {31'b0, mem_req}, 32'h1);
        @(posedge clk);
        #1;
        RST = 1'b0;
        @(negedge clk);
        chk("abort_mem_req", {31'b0, mem_req}, 32'h0);
        chk("abort_stall", {31'b0, stall}, 32'h0);
        chk("abort_hit_cnt", {28'b0, hit_cnt}, 32'h0);
        chk("abort_miss_cnt", {28'b0, miss_cnt}, 32'h0);
        @(posedge clk);
        #1;
        lat = 1;
        do_op(1'b0, 10'h010, 32'h0, 32'hA0, 5);
        chk("reread_hit_cnt", {28'b0, hit_cnt}, 32'h1);
        chk("reread_miss_cnt", {28'b0, miss_cnt}, 32'h1);

        // 16 further hits must pin hit_cnt at its maximum instead of wrapping.
        for (int n = 0; n < 16; n++) do_op(1'b0, 10'h010, 32'h0, 32'hA0, 0);
        chk("sat_hit_cnt", {28'b0, hit_cnt}, 32'hF);
        chk("sat_miss_cnt", {28'b0, miss_cnt}, 32'h1);
        MemRead = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
